// File: rtl/l1_data_sram_ctrl.sv
// Initiator-side controller for the L1 data array: clears the array after reset, then turns
// valid/ready line requests into registered macro drives and returns read data through a small queue.
module l1_data_sram_ctrl #(
    parameter int unsigned DATA_WIDTH = 1024,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_WMASKS = 128,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WMASKS-1:0] wr_mask,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [CNT_W-1:0]      credits;
    logic [CNT_W-1:0]      q_count;
    logic [PTR_W-1:0]      q_wptr;
    logic [PTR_W-1:0]      q_rptr;
    logic [DATA_WIDTH-1:0] q_mem [RSP_DEPTH];
    logic                  rd_cap;
    logic                  collide;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rsp_fire;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Same-line write and read in one cycle: the write wins and the read retries next cycle.
    assign collide   = wr_valid && rd_valid && (wr_addr == rd_addr);
    assign wr_ready  = (state == ST_RUN);
    assign rd_ready  = (state == ST_RUN) && (credits != '0) && !collide;
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_fire   = rd_valid && rd_ready;
    assign rsp_valid = (q_count != '0);
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign rsp_data  = q_mem[q_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            init_done   <= 1'b0;
            sram_csb0   <= 1'b1;
            sram_addr0  <= '0;
            sram_wmask0 <= '0;
            sram_din0   <= '0;
            sram_csb1   <= 1'b1;
            sram_addr1  <= '0;
        end else if (state == ST_INIT) begin
            sram_csb0   <= 1'b0;
            sram_addr0  <= init_cnt;
            sram_wmask0 <= '1;
            sram_din0   <= '0;
            sram_csb1   <= 1'b1;
            init_cnt    <= init_cnt + ADDR_WIDTH'(1);
            if (&init_cnt) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end else begin
            sram_csb0 <= !wr_fire;
            if (wr_fire) begin
                sram_addr0  <= wr_addr;
                sram_wmask0 <= wr_mask;
                sram_din0   <= wr_data;
            end
            sram_csb1 <= !rd_fire;
            if (rd_fire) begin
                sram_addr1 <= rd_addr;
            end
        end
    end

    // Credits cover both reads in the macro pipeline and entries already queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cap  <= 1'b0;
            credits <= CNT_W'(RSP_DEPTH);
            q_count <= '0;
            q_wptr  <= '0;
            q_rptr  <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else begin
            rd_cap <= !sram_csb1;
            if (rd_cap) begin
                q_mem[q_wptr] <= sram_dout1;
                q_wptr        <= ptr_next(q_wptr);
            end
            if (rsp_fire) begin
                q_rptr <= ptr_next(q_rptr);
            end
            case ({rd_cap, rsp_fire})
                2'b10:   q_count <= q_count + CNT_W'(1);
                2'b01:   q_count <= q_count - CNT_W'(1);
                default: q_count <= q_count;
            endcase
            case ({rd_fire, rsp_fire})
                2'b10:   credits <= credits - CNT_W'(1);
                2'b01:   credits <= credits + CNT_W'(1);
                default: credits <= credits;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_data_sram_ctrl.sv
// Scoreboard bench for l1_data_sram_ctrl: behavioural 1W1R macro, line-level reference memory,
// directed scenarios followed by randomized traffic.
module tb_l1_data_sram_ctrl;

    localparam int DW    = 1024;
    localparam int AW    = 8;
    localparam int NW    = 128;
    localparam int RD    = 2;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready, init_done;
    logic [AW-1:0] wr_addr, rd_addr, sram_addr0, sram_addr1;
    logic [NW-1:0] wr_mask, sram_wmask0;
    logic [DW-1:0] wr_data, rsp_data, sram_din0, sram_dout1;
    logic          sram_csb0, sram_csb1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l1_data_sram_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_WMASKS(NW),
        .RSP_DEPTH (RD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_mask    (wr_mask),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .init_done  (init_done),
        .sram_csb0  (sram_csb0),
        .sram_addr0 (sram_addr0),
        .sram_wmask0(sram_wmask0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] l;
        for (int i = 0; i < DW / 32; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    function automatic logic [NW-1:0] rand_mask();
        logic [NW-1:0] m;
        for (int i = 0; i < NW / 32; i++) m[i*32 +: 32] = $urandom();
        return m;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_line(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        logic shown;
        checks++;
        if (act !== exp) begin
            failures++;
            shown = 1'b0;
            for (int i = 0; i < DW / 32; i++) begin
                if (!shown && act[i*32 +: 32] !== exp[i*32 +: 32]) begin
                    $display("FAIL %s: word %0d got %08h expected %08h", nm, i, act[i*32 +: 32], exp[i*32 +: 32]);
                    shown = 1'b1;
                end
            end
        end
    endtask

    // Behavioural macro: ports registered on the rising edge, write then read on the falling edge.
    logic [DW-1:0] macro_mem [DEPTH];
    logic          m_seeded = 1'b0;
    logic          m_csb0, m_csb1;
    logic [AW-1:0] m_a0, m_a1;
    logic [NW-1:0] m_wm;
    logic [DW-1:0] m_din;

    always @(posedge clk) begin
        m_csb0 <= sram_csb0;
        m_a0   <= sram_addr0;
        m_wm   <= sram_wmask0;
        m_din  <= sram_din0;
        m_csb1 <= sram_csb1;
        m_a1   <= sram_addr1;
    end

    always @(negedge clk) begin
        if (!m_seeded) begin
            for (int i = 0; i < DEPTH; i++) macro_mem[i] = rand_line();
            m_seeded = 1'b1;
        end
        if (!m_csb0) begin
            for (int b = 0; b < NW; b++)
                if (m_wm[b]) macro_mem[m_a0][b*8 +: 8] = m_din[b*8 +: 8];
        end
        if (!m_csb1) sram_dout1 <= macro_mem[m_a1];
    end

    // Reference model: a cleared array updated at each accepted write; reads snapshot it at accept.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else begin
            if (wr_valid && wr_ready) begin
                for (int b = 0; b < NW; b++)
                    if (wr_mask[b]) ref_mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
            end
            if (rd_valid && rd_ready) exp_q.push_back(ref_mem[rd_addr]);
        end
    end

    // Monitor: compare every consumed response against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no outstanding read");
            end else begin
                chk_line("rsp_data", rsp_data, exp_q.pop_front());
            end
        end
    end

    // Protocol watchers: held response under backpressure, no same-line dual chip-select.
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                chk_line("rsp_hold_data", rsp_data, hold_data);
            end
            hold_prev = rsp_valid && !rsp_ready;
            hold_data = rsp_data;
            if (!sram_csb0 && !sram_csb1) chk("csb_same_addr", sram_addr0 == sram_addr1, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string nm, input logic [DW-1:0] exp);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        if (!rsp_valid) begin
            checks++;
            failures++;
            $display("FAIL %s: rsp_valid got 0 expected 1 within 20 cycles", nm);
        end else begin
            chk_line(nm, rsp_data, exp);
        end
    endtask

    task automatic init_sweep();
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        wr_addr  = 8'h10;
        rd_addr  = 8'h20;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            chk("init_csb0", sram_csb0, 0);
            chk("init_addr0", sram_addr0, k - 1);
            chk("init_wmask_ones", sram_wmask0 == {NW{1'b1}}, 1);
            chk_line("init_din0", sram_din0, '0);
            chk("init_done", init_done, k == DEPTH);
            chk("init_wr_ready", wr_ready, k == DEPTH);
            chk("init_rd_ready", rd_ready, k == DEPTH);
            chk("init_rsp_valid", rsp_valid, 0);
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        tick();
        chk("idle_csb0", sram_csb0, 1);
        chk("idle_csb1", sram_csb1, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [NW-1:0] m, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_mask  = m;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rd_valid = 1'b1;
        rd_addr  = a;
        #1;
        chk("rd_ready_idle", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] pat_a5, pat_ff, exp_l, col_data;
        int acc;
        logic stall;

        pat_a5 = {(DW / 8){8'hA5}};
        pat_ff = {(DW / 8){8'hFF}};
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        wr_addr   = '0;
        rd_addr   = '0;
        wr_mask   = '0;
        wr_data   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_csb0", sram_csb0, 1);
        chk("rst_csb1", sram_csb1, 1);
        chk("rst_addr0", sram_addr0, 0);
        chk("rst_addr1", sram_addr1, 0);
        chk("rst_wmask0_zero", sram_wmask0 == '0, 1);
        chk_line("rst_din0", sram_din0, '0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk_line("rst_rsp_data", rsp_data, '0);
        chk("rst_init_done", init_done, 0);

        rst_n = 1'b1;
        init_sweep();

        do_read(8'h05);
        wait_rsp("cleared_read", '0);
        repeat (2) tick();

        // Write then read next cycle, 2-cycle response latency.
        do_write(8'h12, '1, pat_a5);
        do_read(8'h12);
        chk("lat_t0", rsp_valid, 0);
        tick();
        chk("lat_t1", rsp_valid, 0);
        tick();
        chk("lat_t2", rsp_valid, 1);
        chk_line("raw_data", rsp_data, pat_a5);
        repeat (2) tick();

        // Partial mask preserves unmasked bytes.
        do_write(8'h40, '1, pat_ff);
        do_write(8'h40, NW'(1), '0);
        do_read(8'h40);
        exp_l = pat_ff;
        exp_l[7:0] = 8'h00;
        wait_rsp("mask_data", exp_l);
        repeat (2) tick();

        // Same-line collision stalls the read by one cycle.
        col_data = rand_line();
        wr_valid = 1'b1;
        wr_addr  = 8'h7F;
        wr_mask  = '1;
        wr_data  = col_data;
        rd_valid = 1'b1;
        rd_addr  = 8'h7F;
        #1;
        chk("col_rd_ready", rd_ready, 0);
        chk("col_wr_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("col_rd_retry", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
        wait_rsp("col_data", col_data);
        repeat (2) tick();

        // Backpressure: only RSP_DEPTH reads accepted, delivered in order.
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            rd_addr = (i == 0) ? 8'h12 : (i == 1) ? 8'h40 : (i == 2) ? 8'h7F : 8'h00;
            #1;
            if (rd_ready) acc++;
            tick();
        end
        chk("bp_accepted", acc, 2);
        chk("bp_rd_ready", rd_ready, 0);
        repeat (3) tick();
        chk("bp_rsp_valid", rsp_valid, 1);
        chk_line("bp_first", rsp_data, pat_a5);
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_second_valid", rsp_valid, 1);
        chk_line("bp_second", rsp_data, exp_l);
        repeat (2) tick();
        chk("bp_drained", rsp_valid, 0);

        // Reset with reads in flight: responses dropped, clear sweep restarts.
        rd_valid = 1'b1;
        rd_addr  = 8'h12;
        tick();
        rd_addr  = 8'h40;
        tick();
        rd_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_csb0", sram_csb0, 1);
        chk("mid_rst_csb1", sram_csb1, 1);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_init_done", init_done, 0);
        tick();
        tick();
        chk("mid_rst_rsp_valid2", rsp_valid, 0);
        rst_n = 1'b1;
        init_sweep();
        do_read(8'h12);
        wait_rsp("recleared_read", '0);
        repeat (2) tick();

        // Randomized traffic on a small address window to provoke collisions and RAW hazards.
        for (int c = 0; c < 400; c++) begin
            if (!stall) begin
                rd_valid = ($urandom_range(0, 1) == 1);
                rd_addr  = AW'($urandom_range(0, 7));
            end
            wr_valid  = ($urandom_range(0, 1) == 1);
            wr_addr   = AW'($urandom_range(0, 7));
            wr_mask   = rand_mask();
            wr_data   = rand_line();
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            stall = rd_valid && !rd_ready;
            tick();
        end
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) tick();
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_rsp_valid", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time got 1000000 expected completion earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
